eth_host_if: RTL

ETH_HOST_IF -- requirements
Module: eth_host_if

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_host_if_if.sv | 22 ++
 rtl/eth_addr_dec.sv | 20 ++
 rtl/eth_host_if.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet host register interface: register
// address map, select width and FSM state encoding.
package eth_pkg;

  localparam int ETH_ADR_W    = 4;
  localparam int ETH_NUM_REGS = 14;

  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MAC0   = 4'h0;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MAC1   = 4'h1;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MAC2   = 4'h2;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MULT0  = 4'h3;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MULT1  = 4'h4;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MULT2  = 4'h5;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_TXALR  = 4'h6;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MINLR  = 4'h7;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_MAXLR  = 4'h8;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_CR     = 4'h9;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_RXCR   = 4'hA;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_TXDDR  = 4'hB;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_RXDTR  = 4'hC;
  localparam logic [ETH_ADR_W-1:0] ETH_ADR_RXDWTR = 4'hD;

  // Transfer FSM: one cycle to access the register file, one cycle of ack,
  // then park until the host releases req.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_REL = 2'd3
  } eth_state_e;

endpackage

// File: rtl/eth_host_if_if.sv
// Host-side bus of the Ethernet register interface.
//
// Handshake (four-phase): the host raises req with we/addr/wdata stable for
// the edge that samples it; the block later pulses ack for exactly one cycle
// (err and a read's rdata are meaningful from that cycle); the host must then
// drop req before another transfer can begin.
interface eth_host_if_if
  import eth_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic                 req;
  logic                 we;
  logic [ETH_ADR_W-1:0] addr;
  logic [WIDTH-1:0]     wdata;
  logic                 ack;
  logic                 err;
  logic [WIDTH-1:0]     rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/eth_addr_dec.sv
// Turns the latched register address into a one-hot register select and
// flags addresses beyond the last register as unmapped.
module eth_addr_dec
  import eth_pkg::*;
(
  input  logic [ETH_ADR_W-1:0]    addr,
  output logic [ETH_NUM_REGS-1:0] sel,
  output logic                    unmapped
);

  // One select bit per mapped register; all zero for unmapped addresses.
  always_comb begin
    sel      = '0;
    unmapped = (addr > ETH_ADR_RXDWTR);
    for (int i = 0; i < ETH_NUM_REGS; i++) begin
      sel[i] = (addr == ETH_ADR_W'(i));
    end
  end

endmodule

// File: rtl/eth_host_if.sv
// Host register interface for the Ethernet MAC: runs the req/ack handshake,
// drives one-cycle write strobes into the register file and returns
// zero-extended readback values.
module eth_host_if
  import eth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res,
  eth_host_if_if.slave     bus,
  output logic [WIDTH-1:0] data,
  output logic             write_mac_0,
  output logic             write_mac_1,
  output logic             write_mac_2,
  output logic             write_mult_0,
  output logic             write_mult_1,
  output logic             write_mult_2,
  output logic             write_txalr,
  output logic             write_minlr,
  output logic             write_maxlr,
  output logic             write_cr,
  output logic             write_rxcr,
  output logic             write_txddr,
  output logic             write_rxdtr,
  output logic             write_rxdwtr,
  input  logic [47:0]      mac_adr,
  input  logic [47:0]      multicast_adr,
  input  logic [4:0]       txalr,
  input  logic [9:0]       minlr,
  input  logic [12:0]      maxlr,
  input  logic             cr,
  input  logic [11:0]      rxcr,
  input  logic [1:0]       txddr,
  input  logic [7:0]       rxdtr,
  input  logic [15:0]      rxdwtr,
  output eth_state_e       dbg_state
);

  eth_state_e              state, state_nx;
  logic                    we_q;
  logic [ETH_ADR_W-1:0]    addr_q;
  logic [ETH_NUM_REGS-1:0] sel;
  logic                    unmapped;
  logic [WIDTH-1:0]        rb_mux;
  logic [WIDTH-1:0]        rdata_q;
  logic                    ack_c;
  logic                    err_c;
  logic                    wr_en;
  logic                    latch_en;

  eth_addr_dec u_dec (
    .addr     (addr_q),
    .sel      (sel),
    .unmapped (unmapped)
  );

  // Transfer state register; reset aborts whatever transfer is in flight.
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    ack_c    = 1'b0;
    err_c    = 1'b0;
    case (state)
      ST_IDLE:     if (bus.req) state_nx = ST_ACCESS;
      ST_ACCESS:   state_nx = ST_ACK;
      ST_ACK: begin
        ack_c    = 1'b1;
        err_c    = unmapped;
        state_nx = ST_WAIT_REL;
      end
      ST_WAIT_REL: if (!bus.req) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  assign latch_en = (state == ST_IDLE) && bus.req;
  assign wr_en    = (state == ST_ACCESS) && we_q;

  // Capture the request when it is accepted so later bus changes cannot
  // disturb the transfer; data only moves on writes so it holds between them.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data   <= '0;
    end else if (latch_en) begin
      we_q   <= bus.we;
      addr_q <= bus.addr;
      if (bus.we) data <= bus.wdata;
    end
  end

  // Readback mux: narrow registers are zero-extended; unmapped selects nothing.
  always_comb begin
    rb_mux = '0;
    if (sel[ETH_ADR_MAC0])   rb_mux = rb_mux | mac_adr[15:0];
    if (sel[ETH_ADR_MAC1])   rb_mux = rb_mux | mac_adr[31:16];
    if (sel[ETH_ADR_MAC2])   rb_mux = rb_mux | mac_adr[47:32];
    if (sel[ETH_ADR_MULT0])  rb_mux = rb_mux | multicast_adr[15:0];
    if (sel[ETH_ADR_MULT1])  rb_mux = rb_mux | multicast_adr[31:16];
    if (sel[ETH_ADR_MULT2])  rb_mux = rb_mux | multicast_adr[47:32];
    if (sel[ETH_ADR_TXALR])  rb_mux = rb_mux | WIDTH'(txalr);
    if (sel[ETH_ADR_MINLR])  rb_mux = rb_mux | WIDTH'(minlr);
    if (sel[ETH_ADR_MAXLR])  rb_mux = rb_mux | WIDTH'(maxlr);
    if (sel[ETH_ADR_CR])     rb_mux = rb_mux | WIDTH'(cr);
    if (sel[ETH_ADR_RXCR])   rb_mux = rb_mux | WIDTH'(rxcr);
    if (sel[ETH_ADR_TXDDR])  rb_mux = rb_mux | WIDTH'(txddr);
    if (sel[ETH_ADR_RXDTR])  rb_mux = rb_mux | WIDTH'(rxdtr);
    if (sel[ETH_ADR_RXDWTR]) rb_mux = rb_mux | WIDTH'(rxdwtr);
  end

  // Read data is loaded only by reads (mapped or not) and then held.
  always_ff @(posedge clk or negedge res) begin
    if (!res)                                rdata_q <= '0;
    else if ((state == ST_ACCESS) && !we_q) rdata_q <= rb_mux;
  end

  assign bus.ack   = ack_c;
  assign bus.err   = err_c;
  assign bus.rdata = rdata_q;
  assign dbg_state = state;

  assign write_mac_0  = wr_en && sel[ETH_ADR_MAC0];
  assign write_mac_1  = wr_en && sel[ETH_ADR_MAC1];
  assign write_mac_2  = wr_en && sel[ETH_ADR_MAC2];
  assign write_mult_0 = wr_en && sel[ETH_ADR_MULT0];
  assign write_mult_1 = wr_en && sel[ETH_ADR_MULT1];
  assign write_mult_2 = wr_en && sel[ETH_ADR_MULT2];
  assign write_txalr  = wr_en && sel[ETH_ADR_TXALR];
  assign write_minlr  = wr_en && sel[ETH_ADR_MINLR];
  assign write_maxlr  = wr_en && sel[ETH_ADR_MAXLR];
  assign write_cr     = wr_en && sel[ETH_ADR_CR];
  assign write_rxcr   = wr_en && sel[ETH_ADR_RXCR];
  assign write_txddr  = wr_en && sel[ETH_ADR_TXDDR];
  assign write_rxdtr  = wr_en && sel[ETH_ADR_RXDTR];
  assign write_rxdwtr = wr_en && sel[ETH_ADR_RXDWTR];

endmodule
